coprocessador_controlador: RTL

Sequencing front-end for the combinational matrix coprocessor (`coprocessador`, N=3 / WIDTH=8 datapath).
- Holds matrices A and B in element-addressed registers, loaded one element per write handshake.
- On a command, drives the datapath for one cycle and registers its packed result.
- Streams the result out one sign-extended element per valid/ready beat.
- Sits between the bus-side register interface and the datapath.

---
 rtl/coprocessador_pkg.sv | 52 +++++
 rtl/coprocessador_controlador_if.sv | 50 +++++
 rtl/coprocessador.sv | 83 ++++++++
 rtl/coprocessador_controlador.sv | 123 ++++++++++++
 4 files changed

// File: rtl/coprocessador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coprocessador_pkg
//  Description : Shared definitions for the matrix coprocessor and its
//                sequencing front-end: default sizes, opcodes, controller
//                state encoding, per-op result stride and stream length.
//  Revision    : 1.0 - initial release
// ============================================================================
package coprocessador_pkg;

    localparam int DEF_N     = 3;
    localparam int DEF_WIDTH = 8;
    localparam int OUT_W     = 3 * DEF_WIDTH + 1;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_SCAL    = 3'd3;
    localparam logic [2:0] OP_TRANS   = 3'd4;
    localparam logic [2:0] OP_NEG     = 3'd5;
    localparam logic [2:0] OP_DET     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        STREAM = 2'd2,
        ERR    = 2'd3
    } state_t;

    // Bit width of one result element inside the packed datapath result.
    // The determinant occupies a single element as wide as the output bus.
    function automatic int stride(input logic [2:0] op, input int width);
        int s;
        case (op)
            OP_ADD, OP_SUB, OP_NEG: s = width + 1;
            OP_MUL:                 s = 2 * width + 3;
            OP_SCAL:                s = 2 * width;
            OP_TRANS:               s = width;
            OP_DET:                 s = 3 * width + 1;
            default:                s = width;
        endcase
        return s;
    endfunction

    // Number of output beats produced by one command.
    function automatic int stream_len(input logic [2:0] op, input int n);
        return (op == OP_DET) ? 1 : n * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coprocessador_controlador_if.sv
`default_nettype none
// ============================================================================
//  Module      : coprocessador_controlador_if
//  Description : Bus-side bundle of the coprocessor controller.
//                write port : wr_valid/wr_ready, wr_sel, wr_addr, wr_data
//                command    : cmd_valid/cmd_ready, cmd_op, cmd_escalar
//                result     : out_valid/out_ready, out_data, out_last
//                status     : busy, err
//                master = requester/consumer side, slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface coprocessador_controlador_if
    import coprocessador_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int AW = $clog2(N * N);
    localparam int OW = 3 * WIDTH + 1;

    logic             wr_valid;
    logic             wr_ready;
    logic             wr_sel;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_escalar;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic             out_last;
    logic             busy;
    logic             err;

    modport master (
        output wr_valid, wr_sel, wr_addr, wr_data,
        output cmd_valid, cmd_op, cmd_escalar, out_ready,
        input  wr_ready, cmd_ready, out_valid, out_data, out_last, busy, err
    );

    modport slave (
        input  wr_valid, wr_sel, wr_addr, wr_data,
        input  cmd_valid, cmd_op, cmd_escalar, out_ready,
        output wr_ready, cmd_ready, out_valid, out_data, out_last, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/coprocessador.sv
`default_nettype none
// ============================================================================
//  Module      : coprocessador
//  Description : Combinational N x N signed matrix datapath.
//                i_a, i_b        : row-major packed matrices, WIDTH per element
//                i_operacao      : opcode (add/sub/mul/scalar/transpose/neg)
//                i_escalar       : signed scalar for scalar-multiply
//                o_resultado     : packed result, element k at [k*S +: S],
//                                  S depending on the opcode
//                o_det           : determinant of i_a (N = 3 only)
//  Revision    : 1.0 - initial release
// ============================================================================
module coprocessador
    import coprocessador_pkg::*;
#(
    parameter  int N     = DEF_N,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int RES_W = N * N * (2 * WIDTH + 3),
    localparam int DET_W = 3 * WIDTH + 1
) (
    input  logic [N*N*WIDTH-1:0] i_a,
    input  logic [N*N*WIDTH-1:0] i_b,
    input  logic [2:0]           i_operacao,
    input  logic [WIDTH-1:0]     i_escalar,
    output logic [RES_W-1:0]     o_resultado,
    output logic [DET_W-1:0]     o_det
);
    localparam int NE = N * N;
    localparam int SA = WIDTH + 1;
    localparam int SM = 2 * WIDTH + 3;
    localparam int SS = 2 * WIDTH;

    logic signed [WIDTH-1:0] w_ea [NE];
    logic signed [WIDTH-1:0] w_eb [NE];
    logic signed [WIDTH-1:0] w_esc;

    assign w_esc = i_escalar;

    for (genvar k = 0; k < NE; k++) begin : g_unpack
        assign w_ea[k] = i_a[k*WIDTH +: WIDTH];
        assign w_eb[k] = i_b[k*WIDTH +: WIDTH];
    end

    always_comb begin : p_result
        logic signed [SM-1:0] acc;
        o_resultado = '0;
        acc         = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (i_operacao)
                    OP_ADD:   o_resultado[(r*N+c)*SA +: SA] = SA'(w_ea[r*N+c]) + SA'(w_eb[r*N+c]);
                    OP_SUB:   o_resultado[(r*N+c)*SA +: SA] = SA'(w_ea[r*N+c]) - SA'(w_eb[r*N+c]);
                    OP_MUL: begin
                        acc = '0;
                        for (int m = 0; m < N; m++) begin
                            acc = acc + SM'(w_ea[r*N+m]) * SM'(w_eb[m*N+c]);
                        end
                        o_resultado[(r*N+c)*SM +: SM] = acc;
                    end
                    OP_SCAL:  o_resultado[(r*N+c)*SS +: SS] = SS'(w_ea[r*N+c]) * SS'(w_esc);
                    OP_TRANS: o_resultado[(r*N+c)*WIDTH +: WIDTH] = w_ea[c*N+r];
                    OP_NEG:   o_resultado[(r*N+c)*SA +: SA] = -SA'(w_ea[r*N+c]);
                    default:  ;
                endcase
            end
        end
    end

    // Cofactor expansion along row 0; only defined for the 3x3 datapath.
    if (N == 3) begin : g_det
        logic signed [DET_W-1:0] w_x [9];
        for (genvar k = 0; k < 9; k++) begin : g_ext
            assign w_x[k] = DET_W'(w_ea[k]);
        end
        assign o_det = w_x[0] * (w_x[4] * w_x[8] - w_x[5] * w_x[7])
                     - w_x[1] * (w_x[3] * w_x[8] - w_x[5] * w_x[6])
                     + w_x[2] * (w_x[3] * w_x[7] - w_x[4] * w_x[6]);
    end else begin : g_no_det
        assign o_det = '0;
    end

endmodule
`default_nettype wire

// File: rtl/coprocessador_controlador.sv
`default_nettype none
// ============================================================================
//  Module      : coprocessador_controlador
//  Description : Sequencing front-end for the matrix coprocessor. Holds A/B
//                element registers written over the bus, runs one command
//                through the datapath, captures the result and streams it out
//                one sign-extended element per valid/ready beat.
//                clk, rst : clock, synchronous active-high reset
//                bus      : write / command / result / status bundle (slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module coprocessador_controlador
    import coprocessador_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    coprocessador_controlador_if.slave    bus
);
    localparam int NE    = N * N;
    localparam int AW    = $clog2(NE);
    localparam int RES_W = NE * (2 * WIDTH + 3);
    localparam int OW    = 3 * WIDTH + 1;

    state_t                     r_state;
    state_t                     w_next;
    logic [NE-1:0][WIDTH-1:0]   r_a;
    logic [NE-1:0][WIDTH-1:0]   r_b;
    logic [2:0]                 r_op;
    logic [WIDTH-1:0]           r_esc;
    logic [RES_W-1:0]           r_res;
    logic [AW-1:0]              r_cnt;
    logic [RES_W-1:0]           w_res;
    logic [OW-1:0]              w_det;
    logic signed [OW-1:0]       w_elem;
    logic                       w_last;
    logic                       w_idle;

    coprocessador #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_datapath (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_operacao  (r_op),
        .i_escalar   (r_esc),
        .o_resultado (w_res),
        .o_det       (w_det)
    );

    assign w_idle = (r_state == IDLE);
    assign w_last = (r_state == STREAM) && (int'(r_cnt) == stream_len(r_op, N) - 1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.cmd_valid) w_next = (bus.cmd_op == OP_ILLEGAL) ? ERR : EXEC;
            EXEC:    w_next = STREAM;
            STREAM:  if (bus.out_ready && w_last) w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_esc <= '0;
            r_res <= '0;
            r_cnt <= '0;
        end else begin
            // Out-of-range element addresses complete the handshake but
            // touch nothing.
            if (w_idle && bus.wr_valid && (int'(bus.wr_addr) < NE)) begin
                if (bus.wr_sel) r_b[bus.wr_addr] <= bus.wr_data;
                else            r_a[bus.wr_addr] <= bus.wr_data;
            end
            if (w_idle && bus.cmd_valid && (bus.cmd_op != OP_ILLEGAL)) begin
                r_op  <= bus.cmd_op;
                r_esc <= bus.cmd_escalar;
            end
            case (r_state)
                EXEC: begin
                    r_res <= (r_op == OP_DET) ? RES_W'(w_det) : w_res;
                    r_cnt <= '0;
                end
                // The counter stops on the last beat so out_data stays valid.
                STREAM: if (bus.out_ready && !w_last) r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Element extraction: shift the selected element down, then sign-extend
    // from its stride by a left/arithmetic-right shift pair.
    always_comb begin : p_extract
        logic signed [OW-1:0] t;
        int                   s;
        s      = stride(r_op, WIDTH);
        t      = OW'(r_res >> (int'(r_cnt) * s));
        t      = t <<< (OW - s);
        w_elem = t >>> (OW - s);
    end

    assign bus.wr_ready  = w_idle;
    assign bus.cmd_ready = w_idle;
    assign bus.busy      = !w_idle;
    assign bus.err       = (r_state == ERR);
    assign bus.out_valid = (r_state == STREAM);
    assign bus.out_last  = w_last;
    assign bus.out_data  = w_elem;

endmodule
`default_nettype wire
